// File: rtl/ball_engine_param.sv
// Pong ball engine: serve delay at centre, 2-D motion with wall and paddle
// reflection, miss detection with score pulses, and stepwise speed-up.
module ball_engine_param #(
  parameter int HOR_PIXELS   = 1024,
  parameter int VER_PIXELS   = 768,
  parameter int BALL_SIZE    = 15,
  parameter int PAD_W        = 15,
  parameter int PAD_H        = 145,
  parameter int X_PAD_L      = 30,
  parameter int X_PAD_R      = 979,
  parameter int VEL_INIT     = 2,
  parameter int VEL_MAX      = 8,
  parameter int SPEEDUP_HITS = 4,
  parameter int SERVE_TICKS  = 60
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        timing_tick,
  input  logic        enable,
  input  logic [9:0]  y_pad_left,
  input  logic [9:0]  y_pad_right,
  output logic [10:0] x_ball,
  output logic [9:0]  y_ball,
  output logic [3:0]  speed,
  output logic        serving,
  output logic        hit_pulse,
  output logic        wall_pulse,
  output logic        score_left,
  output logic        score_right
);

  localparam int XC      = (HOR_PIXELS - BALL_SIZE) / 2;
  localparam int YC      = (VER_PIXELS - BALL_SIZE) / 2;
  localparam int Y_MAX   = VER_PIXELS - BALL_SIZE;
  localparam int X_L_HIT = X_PAD_L + PAD_W;
  localparam int X_R_HIT = X_PAD_R - BALL_SIZE;
  localparam int CW      = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;
  localparam int HW      = (SPEEDUP_HITS > 1) ? $clog2(SPEEDUP_HITS) : 1;

  localparam logic signed [11:0] S_YMAX = 12'(Y_MAX);
  localparam logic signed [11:0] S_XLH  = 12'(X_L_HIT);
  localparam logic signed [11:0] S_XRH  = 12'(X_R_HIT);
  localparam logic signed [11:0] S_BALL = 12'(BALL_SIZE);
  localparam logic signed [11:0] S_HOR  = 12'(HOR_PIXELS);
  localparam logic signed [11:0] S_PADH = 12'(PAD_H);

  typedef enum logic [1:0] {S_IDLE, S_SERVE, S_MOVE, S_SCORED} state_t;

  state_t         r_state, w_state_n;
  logic [10:0]    r_x, w_x_n;
  logic [9:0]     r_y, w_y_n;
  logic [3:0]     r_speed, w_speed_n;
  logic           r_right, w_right_n;
  logic           r_down, w_down_n;
  logic [HW-1:0]  r_hits, w_hits_n;
  logic [CW-1:0]  r_cnt, w_cnt_n;
  logic           r_hit, r_wall, r_sl, r_sr;
  logic           w_hit, w_wall, w_sl, w_sr;
  logic signed [11:0] w_xs, w_ys, w_v, w_nx, w_ny, w_ypl, w_ypr;
  logic           w_ovl_l, w_ovl_r;

  // All position arithmetic is 12-bit signed so under/overflow is visible.
  assign w_xs    = signed'({1'b0, r_x});
  assign w_ys    = signed'({2'b00, r_y});
  assign w_v     = signed'({8'h00, r_speed});
  assign w_ypl   = signed'({2'b00, y_pad_left});
  assign w_ypr   = signed'({2'b00, y_pad_right});
  assign w_ovl_l = (w_ys + S_BALL > w_ypl) && (w_ys < w_ypl + S_PADH);
  assign w_ovl_r = (w_ys + S_BALL > w_ypr) && (w_ys < w_ypr + S_PADH);

  always_comb begin
    w_state_n = r_state;
    w_x_n     = r_x;
    w_y_n     = r_y;
    w_speed_n = r_speed;
    w_right_n = r_right;
    w_down_n  = r_down;
    w_hits_n  = r_hits;
    w_cnt_n   = r_cnt;
    w_hit     = 1'b0;
    w_wall    = 1'b0;
    w_sl      = 1'b0;
    w_sr      = 1'b0;
    w_nx      = '0;
    w_ny      = '0;
    case (r_state)
      S_IDLE: begin
        w_cnt_n = '0;
        if (enable) w_state_n = S_SERVE;
      end
      S_SERVE: begin
        if (timing_tick) begin
          if (r_cnt == CW'(SERVE_TICKS - 1)) begin
            w_cnt_n   = '0;
            w_state_n = S_MOVE;
          end else begin
            w_cnt_n = r_cnt + 1'b1;
          end
        end
      end
      S_MOVE: begin
        if (timing_tick) begin
          if (r_down) begin
            w_ny = w_ys + w_v;
            if (w_ny >= S_YMAX) begin
              w_y_n    = 10'(Y_MAX);
              w_down_n = 1'b0;
              w_wall   = 1'b1;
            end else begin
              w_y_n = w_ny[9:0];
            end
          end else begin
            w_ny = w_ys - w_v;
            if (w_ys <= w_v) begin
              w_y_n    = '0;
              w_down_n = 1'b1;
              w_wall   = 1'b1;
            end else begin
              w_y_n = w_ny[9:0];
            end
          end

          // Paddle test is evaluated before the miss test so it wins on a shared tick.
          if (!r_right) begin
            w_nx = w_xs - w_v;
            if (w_nx <= S_XLH && w_xs >= S_XLH && w_ovl_l) begin
              w_x_n     = 11'(X_L_HIT);
              w_right_n = 1'b1;
              w_hit     = 1'b1;
            end else if (w_nx <= 12'sd0) begin
              w_sr = 1'b1;
            end else begin
              w_x_n = w_nx[10:0];
            end
          end else begin
            w_nx = w_xs + w_v;
            if (w_nx >= S_XRH && w_xs <= S_XRH && w_ovl_r) begin
              w_x_n     = 11'(X_R_HIT);
              w_right_n = 1'b0;
              w_hit     = 1'b1;
            end else if (w_nx + S_BALL >= S_HOR) begin
              w_sl = 1'b1;
            end else begin
              w_x_n = w_nx[10:0];
            end
          end

          if (w_hit) begin
            if (r_hits == HW'(SPEEDUP_HITS - 1)) begin
              w_hits_n = '0;
              if (r_speed < 4'(VEL_MAX)) w_speed_n = r_speed + 4'd1;
            end else begin
              w_hits_n = r_hits + 1'b1;
            end
          end

          if (w_sl || w_sr) begin
            w_x_n     = 11'(XC);
            w_y_n     = 10'(YC);
            w_speed_n = 4'(VEL_INIT);
            w_hits_n  = '0;
            w_right_n = w_sr;
            w_down_n  = 1'b0;
            w_state_n = S_SCORED;
          end
        end
      end
      S_SCORED: begin
        if (timing_tick) begin
          w_cnt_n   = '0;
          w_state_n = S_SERVE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      r_state <= S_IDLE;
      r_x     <= 11'(XC);
      r_y     <= 10'(YC);
      r_speed <= 4'(VEL_INIT);
      r_right <= 1'b1;
      r_down  <= 1'b0;
      r_hits  <= '0;
      r_cnt   <= '0;
      r_hit   <= 1'b0;
      r_wall  <= 1'b0;
      r_sl    <= 1'b0;
      r_sr    <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_x     <= w_x_n;
      r_y     <= w_y_n;
      r_speed <= w_speed_n;
      r_right <= w_right_n;
      r_down  <= w_down_n;
      r_hits  <= w_hits_n;
      r_cnt   <= w_cnt_n;
      r_hit   <= w_hit;
      r_wall  <= w_wall;
      r_sl    <= w_sl;
      r_sr    <= w_sr;
    end
  end

  assign x_ball      = r_x;
  assign y_ball      = r_y;
  assign speed       = r_speed;
  assign serving     = (r_state == S_IDLE) || (r_state == S_SERVE);
  assign hit_pulse   = r_hit;
  assign wall_pulse  = r_wall;
  assign score_left  = r_sl;
  assign score_right = r_sr;

endmodule

// File: tb/tb_ball_engine_param.sv
// Directed bench for ball_engine_param: default-geometry rallies plus a
// reshaped field where a paddle hit and a wall bounce land on one tick.
module tb_ball_engine_param;

  logic        clk;
  logic        rst;
  logic        timing_tick;
  logic        enable, enable2;
  logic [9:0]  ypl, ypr, ypl2, ypr2;
  logic [10:0] x_ball, x_ball2;
  logic [9:0]  y_ball, y_ball2;
  logic [3:0]  speed, speed2;
  logic        serving, hit_pulse, wall_pulse, score_left, score_right;
  logic        serving2, hit_pulse2, wall_pulse2, score_left2, score_right2;
  logic        track;
  int          n_checks = 0;
  int          n_errors = 0;

  ball_engine_param dut (
    .clk(clk), .rst(rst), .timing_tick(timing_tick), .enable(enable),
    .y_pad_left(ypl), .y_pad_right(ypr),
    .x_ball(x_ball), .y_ball(y_ball), .speed(speed), .serving(serving),
    .hit_pulse(hit_pulse), .wall_pulse(wall_pulse),
    .score_left(score_left), .score_right(score_right)
  );

  // Field sized so the ball reaches the right paddle exactly on a bottom bounce.
  ball_engine_param #(
    .HOR_PIXELS(815), .VER_PIXELS(271), .X_PAD_R(799), .SERVE_TICKS(2)
  ) dut2 (
    .clk(clk), .rst(rst), .timing_tick(timing_tick), .enable(enable2),
    .y_pad_left(ypl2), .y_pad_right(ypr2),
    .x_ball(x_ball2), .y_ball(y_ball2), .speed(speed2), .serving(serving2),
    .hit_pulse(hit_pulse2), .wall_pulse(wall_pulse2),
    .score_left(score_left2), .score_right(score_right2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    timing_tick = 1'b1;
    @(negedge clk);
    timing_tick = 1'b0;
    if (track) begin
      ypl = (y_ball >= 10'd60) ? y_ball - 10'd60 : 10'd0;
      ypr = ypl;
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // From the first MOVE tick of a rightward-up serve to one tick before the left paddle.
  task automatic rally();
    tick();
    chk("mv1_x", x_ball, 506);
    chk("mv1_y", y_ball, 374);
    ticks(186);
    chk("t187_y", y_ball, 2);
    chk("t187_x", x_ball, 878);
    tick();
    chk("top_y", y_ball, 0);
    chk("top_x", x_ball, 880);
    chk("top_wall", wall_pulse, 1);
    ticks(41);
    chk("t229_x", x_ball, 962);
    chk("t229_hit", hit_pulse, 0);
    tick();
    chk("rp_x", x_ball, 964);
    chk("rp_y", y_ball, 84);
    chk("rp_hit", hit_pulse, 1);
    ticks(334);
    chk("t564_y", y_ball, 752);
    tick();
    chk("bot_y", y_ball, 753);
    chk("bot_x", x_ball, 294);
    chk("bot_wall", wall_pulse, 1);
    ticks(124);
    chk("t689_x", x_ball, 46);
    chk("t689_y", y_ball, 505);
  endtask

  initial begin
    int nh;
    int budget;
    int exp_spd;
    rst = 1'b1; enable = 1'b0; enable2 = 1'b0; timing_tick = 1'b0;
    ypl = '0; ypr = '0; ypl2 = '0; ypr2 = 10'd200; track = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_x", x_ball, 504);
    chk("rst_y", y_ball, 376);
    chk("rst_speed", speed, 2);
    chk("rst_serving", serving, 1);
    chk("rst_pulses", {hit_pulse, wall_pulse, score_left, score_right}, 0);

    rst = 1'b0; enable = 1'b1;
    repeat (2) @(negedge clk);
    chk("serve_x", x_ball, 504);
    chk("serve_serving", serving, 1);
    ticks(59);
    chk("serve59_serving", serving, 1);
    tick();
    chk("serve60_serving", serving, 0);
    chk("serve60_x", x_ball, 504);
    chk("serve60_y", y_ball, 376);

    // Pass 1: left paddle out of reach, ball runs off the left edge.
    rally();
    tick();
    chk("nohit_x", x_ball, 44);
    chk("nohit_y", y_ball, 503);
    chk("nohit_hit", hit_pulse, 0);
    ticks(21);
    chk("t711_x", x_ball, 2);
    chk("t711_sr", score_right, 0);
    tick();
    chk("miss_sr", score_right, 1);
    chk("miss_sl", score_left, 0);
    chk("miss_x", x_ball, 504);
    chk("miss_y", y_ball, 376);
    chk("miss_speed", speed, 2);
    chk("scored_serving", serving, 0);
    tick();
    chk("reserve_serving", serving, 1);
    chk("reserve_sr", score_right, 0);
    ticks(60);
    chk("reserve60_serving", serving, 0);

    // Pass 2: same flight, left paddle positioned to return it.
    ypl = 10'd400;
    rally();
    tick();
    chk("lp_x", x_ball, 45);
    chk("lp_y", y_ball, 503);
    chk("lp_hit", hit_pulse, 1);
    chk("lp_speed", speed, 2);
    tick();
    chk("lp_dir_x", x_ball, 47);
    chk("lp_dir_y", y_ball, 501);

    // Paddles follow the ball; speed steps every fourth hit and saturates.
    track = 1'b1;
    ypl = (y_ball >= 10'd60) ? y_ball - 10'd60 : 10'd0;
    ypr = ypl;
    nh = 2;
    budget = 15000;
    while (nh < 28 && budget > 0) begin
      tick();
      budget--;
      if (hit_pulse) begin
        nh++;
        exp_spd = 2 + nh / 4;
        if (exp_spd > 8) exp_spd = 8;
        chk($sformatf("speed_hit%0d", nh), speed, exp_spd);
      end
    end
    chk("track_hits_done", nh, 28);
    chk("track_speed_sat", speed, 8);
    track = 1'b0;

    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    chk("drop_x", x_ball, 504);
    chk("drop_y", y_ball, 376);
    chk("drop_speed", speed, 2);
    chk("drop_serving", serving, 1);
    chk("drop_score", {score_left, score_right}, 0);

    // Corner on the reshaped field: centre (400,128), right paddle clamp x=784, floor y=256.
    enable2 = 1'b1;
    @(negedge clk);
    ticks(2);
    chk("c_serving", serving2, 0);
    ticks(63);
    chk("c_t63_x", x_ball2, 526);
    chk("c_t63_y", y_ball2, 2);
    tick();
    chk("c_top_y", y_ball2, 0);
    chk("c_top_wall", wall_pulse2, 1);
    ticks(127);
    chk("c_t191_x", x_ball2, 782);
    chk("c_t191_y", y_ball2, 254);
    tick();
    chk("corner_x", x_ball2, 784);
    chk("corner_y", y_ball2, 256);
    chk("corner_hit", hit_pulse2, 1);
    chk("corner_wall", wall_pulse2, 1);
    tick();
    chk("corner_dir_x", x_ball2, 782);
    chk("corner_dir_y", y_ball2, 254);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
